cla_addsub64_pipe: RTL and testbench
====================================

# cla_addsub64_pipe

Two-stage pipelined 64-bit adder/subtractor built on the team's 16-bit carry look-ahead slices. Operands enter through a valid/ready handshake. Stage 1 resolves the low 32 bits and registers the mid carry. Stage 2 resolves the high 32 bits and produces the flags. It is the arithmetic consumer of the carry look-ahead network and adds the subtract direction (borrow chain), which the CLA tree alone does not provide.

## Interface
- `W`, default 64: operand width; fixed at 64, split into two 32-bit halves of two 16-bit CLA slices each.
- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block accepts a beat this cycle.
- `op` in 1: 0 = add, 1 = subtract.
- `a`, `b` in 64: unsigned/two's-complement operands.
- `cin` in 1: carry-in when `op`=0; borrow-in when `op`=1.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: downstream accepts the result.
- `res` out 64: sum or difference, modulo 2^64.
- `cout` out 1: carry-out (add) or borrow-out (sub).
- `ovf` out 1: signed two's-complement overflow.
- `zero` out 1: `res` == 0.

## Operation
- Effective operand: `bb` = `op` ? ~`b` : `b`. Effective carry-in: `ci` = `op` ? ~`cin` : `cin`.
- Result: `res` = `a` + `bb` + `ci` (mod 2^64).
- Subtract therefore computes `a` − `b` − `cin`.
- Raw carry c64 = carry out of bit 63. `cout` = `op` ? ~c64 : c64, so 1 means borrow on subtract.
- Overflow: `ovf` = c64 XOR c63, where c63 is the carry into bit 63.
- Stage 1 (on accept):
  - p = a^bb, g = a&bb on bits 31:0; CLA slices produce c1..c32 from `ci`.
  - Register res[31:0], c32, a[63:32], bb[63:32], `op`; set s1_valid.
- Stage 2 (on advance):
  - CLA on bits 63:32 with carry-in c32.
  - Register `res`[63:0], `cout`, `ovf`, `zero`; set s2_valid (= `out_valid`).
- Flow control (skid-free, full throughput):
  - s2_adv = s1_valid & (!s2_valid | `out_ready`).
  - `in_ready` = !s1_valid | s2_adv.
  - Combinational from `out_ready`; no path from `in_valid` to `in_ready`.
- Pipeline register updates:
  - s1 loads when `in_valid` & `in_ready`.
  - s1_valid clears when s2_adv occurs without a new accept.
  - s2 holds payload while `out_valid` & !`out_ready`.
  - s2_valid clears when `out_ready` & !s2_adv.
- Payload registers are written only on their load condition. `res`, `cout`, `ovf`, `zero` are stable while `out_valid` is held.

## Timing
- Reset (async assert, sync-safe deassert at `clk`): s1_valid=0, s2_valid=0, `out_valid`=0, `res`=0, `cout`=0, `ovf`=0, `zero`=0. `in_ready`=1 immediately after reset asserts.
- Latency: beat accepted at edge N → `out_valid`=1 with its result after edge N+1.
- Throughput: 1 beat/cycle while `out_ready`=1.
- Capacity: 2 beats in flight.
- Full: both stages valid and `out_ready`=0 → `in_ready`=0. No beat is lost or overwritten.
- Simultaneous drain and fill: with both stages full and `out_ready`=1, `in_ready`=1. Accept, advance and drain all occur in the same edge.
- Empty pipe: no spurious `out_valid`. Inputs with `in_valid`=0 are ignored regardless of value.
- Reset mid-operation: in-flight beats are discarded and no result is emitted. The first post-reset accept is the first output.
- Wrap-around: modulo 2^64, with no saturation.

## Test plan
- Reset: assert `rst` with both stages full → `out_valid`=0 and `res`=0 asynchronously; `in_ready`=1.
- Add with full carry ripple: `a`=0xFFFF_FFFF_FFFF_FFFF, `b`=0, `cin`=1, `op`=0 → `res`=0, `cout`=1, `zero`=1, `ovf`=0, two cycles later.
- Subtract with borrow: `a`=0, `b`=1, `cin`=0, `op`=1 → `res`=0xFFFF_FFFF_FFFF_FFFF, `cout`=1 (borrow), `ovf`=0. Then `a`=5, `b`=3, `cin`=1 → `res`=1, `cout`=0.
- Signed overflow: `a`=0x7FFF_FFFF_FFFF_FFFF, `b`=1, `op`=0, `cin`=0 → `res`=0x8000_0000_0000_0000, `ovf`=1, `cout`=0.
- Backpressure: stream 5 beats with `out_ready`=0 → exactly 2 accepted and `in_ready`=0 after that. Release `out_ready` → results emerge in order, stable while held, and none is duplicated.
- Random streaming: 10k random beats with random `in_valid`/`out_ready` → every output matches the a±b±cin reference model in order; steady-state throughput is 1/cycle when both are held high.

Source files
------------

// File: rtl/cla_addsub64_pipe.sv
// ---------------------------------------------------------------------------
// cla_addsub64_pipe
//
// Two-stage pipelined 64-bit adder/subtractor built from 16-bit carry
// look-ahead slices. Subtraction is done as a + ~b + ~cin, so the carry
// chain doubles as the borrow chain and cout is inverted back into a borrow.
//
//   Stage 1: bits 31:0 resolved through two CLA slices; the mid carry (c32),
//            the upper operand halves and the op bit are registered.
//   Stage 2: bits 63:32 resolved from the registered c32; result and flags
//            are registered and presented with o_out_valid.
//
// Ports
//   i_clk        clock, rising edge
//   i_rst        asynchronous active-high reset
//   i_in_valid   operand beat valid
//   o_in_ready   block accepts a beat this cycle (depends on i_out_ready,
//                never on i_in_valid)
//   i_op         0 = add, 1 = subtract
//   i_a, i_b     64-bit operands
//   i_cin        carry-in (add) / borrow-in (subtract)
//   o_out_valid  result beat valid
//   i_out_ready  downstream accepts the result
//   o_res        sum or difference, modulo 2^64
//   o_cout       carry-out (add) / borrow-out (subtract)
//   o_ovf        signed two's-complement overflow
//   o_zero       o_res == 0
// ---------------------------------------------------------------------------
module cla_addsub64_pipe #(
    parameter int unsigned W = 64  // fixed at 64: two halves of two 16-bit slices
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_in_valid,
    output logic         o_in_ready,
    input  logic         i_op,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic         o_out_valid,
    input  logic         i_out_ready,
    output logic [W-1:0] o_res,
    output logic         o_cout,
    output logic         o_ovf,
    output logic         o_zero
);

    // -----------------------------------------------------------------------
    // 16-bit carry look-ahead slice.
    // Returns c[16:0] where c[0] is the slice carry-in and c[i] is the carry
    // into bit i (c[16] is the slice carry-out). Four 4-bit groups produce
    // group generate/propagate; a second look-ahead level produces the group
    // carries, then each group expands its internal carries from its own
    // group carry, so no carry ripples across more than one level.
    // -----------------------------------------------------------------------
    function automatic logic [16:0] cla16(input logic [15:0] p,
                                          input logic [15:0] g,
                                          input logic        ci);
        logic [3:0]  gg;
        logic [3:0]  gp;
        logic [4:0]  gc;
        logic [16:0] c;
        int          base;

        for (int k = 0; k < 4; k++) begin
            base  = 4 * k;
            gp[k] = &p[base +: 4];
            gg[k] = g[base+3]
                  | (p[base+3] & g[base+2])
                  | (p[base+3] & p[base+2] & g[base+1])
                  | (p[base+3] & p[base+2] & p[base+1] & g[base]);
        end

        gc[0] = ci;
        gc[1] = gg[0] | (gp[0] & ci);
        gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
        gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
              | (gp[2] & gp[1] & gp[0] & ci);
        gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
              | (gp[3] & gp[2] & gp[1] & gg[0])
              | (gp[3] & gp[2] & gp[1] & gp[0] & ci);

        for (int k = 0; k < 4; k++) begin
            base        = 4 * k;
            c[base]     = gc[k];
            c[base + 1] = g[base] | (p[base] & gc[k]);
            c[base + 2] = g[base+1] | (p[base+1] & g[base])
                        | (p[base+1] & p[base] & gc[k]);
            c[base + 3] = g[base+2] | (p[base+2] & g[base+1])
                        | (p[base+2] & p[base+1] & g[base])
                        | (p[base+2] & p[base+1] & p[base] & gc[k]);
        end
        c[16] = gc[4];
        return c;
    endfunction

    // -----------------------------------------------------------------------
    // Flow control
    // -----------------------------------------------------------------------
    logic r_s1_valid;
    logic r_s2_valid;
    logic w_s2_adv;
    logic w_accept;

    // Stage 2 takes stage 1's beat when its own slot is empty or draining.
    assign w_s2_adv   = r_s1_valid & (~r_s2_valid | i_out_ready);
    assign o_in_ready = ~r_s1_valid | w_s2_adv;
    assign w_accept   = i_in_valid & o_in_ready;

    // -----------------------------------------------------------------------
    // Stage 1: low half
    // -----------------------------------------------------------------------
    logic [63:0] w_bb;
    logic        w_ci;
    logic [31:0] w_p_lo;
    logic [31:0] w_g_lo;
    logic [16:0] w_c_lo0;
    logic [16:0] w_c_lo1;
    logic [31:0] w_sum_lo;

    // Subtract folds into the adder: a - b - cin == a + ~b + ~cin.
    assign w_bb     = i_op ? ~i_b : i_b;
    assign w_ci     = i_op ^ i_cin;
    assign w_p_lo   = i_a[31:0] ^ w_bb[31:0];
    assign w_g_lo   = i_a[31:0] & w_bb[31:0];
    assign w_c_lo0  = cla16(w_p_lo[15:0], w_g_lo[15:0], w_ci);
    assign w_c_lo1  = cla16(w_p_lo[31:16], w_g_lo[31:16], w_c_lo0[16]);
    assign w_sum_lo = w_p_lo ^ {w_c_lo1[15:0], w_c_lo0[15:0]};

    logic [31:0] r_s1_res_lo;
    logic        r_s1_c32;
    logic [31:0] r_s1_a_hi;
    logic [31:0] r_s1_bb_hi;
    logic        r_s1_op;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
        end else if (w_s2_adv) begin
            r_s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s1_res_lo <= '0;
            r_s1_c32    <= 1'b0;
            r_s1_a_hi   <= '0;
            r_s1_bb_hi  <= '0;
            r_s1_op     <= 1'b0;
        end else if (w_accept) begin
            r_s1_res_lo <= w_sum_lo;
            r_s1_c32    <= w_c_lo1[16];
            r_s1_a_hi   <= i_a[63:32];
            r_s1_bb_hi  <= w_bb[63:32];
            r_s1_op     <= i_op;
        end
    end

    // -----------------------------------------------------------------------
    // Stage 2: high half and flags
    // -----------------------------------------------------------------------
    logic [31:0] w_p_hi;
    logic [31:0] w_g_hi;
    logic [16:0] w_c_hi0;
    logic [16:0] w_c_hi1;
    logic [31:0] w_sum_hi;
    logic [63:0] w_res;
    logic        w_c63;
    logic        w_c64;

    assign w_p_hi   = r_s1_a_hi ^ r_s1_bb_hi;
    assign w_g_hi   = r_s1_a_hi & r_s1_bb_hi;
    assign w_c_hi0  = cla16(w_p_hi[15:0], w_g_hi[15:0], r_s1_c32);
    assign w_c_hi1  = cla16(w_p_hi[31:16], w_g_hi[31:16], w_c_hi0[16]);
    assign w_sum_hi = w_p_hi ^ {w_c_hi1[15:0], w_c_hi0[15:0]};
    assign w_res    = {w_sum_hi, r_s1_res_lo};
    // c63 is the carry into bit 63, i.e. into bit 15 of the top slice.
    assign w_c63    = w_c_hi1[15];
    assign w_c64    = w_c_hi1[16];

    logic [63:0] r_res;
    logic        r_cout;
    logic        r_ovf;
    logic        r_zero;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
        end else if (w_s2_adv) begin
            r_s2_valid <= 1'b1;
        end else if (i_out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    // Payload only moves on advance, so it is held while the consumer stalls.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_res  <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else if (w_s2_adv) begin
            r_res  <= w_res;
            r_cout <= r_s1_op ^ w_c64;  // raw carry inverted into a borrow on subtract
            r_ovf  <= w_c64 ^ w_c63;
            r_zero <= (w_res == 64'd0);
        end
    end

    assign o_out_valid = r_s2_valid;
    assign o_res       = r_res;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;
    assign o_zero      = r_zero;

endmodule

// File: tb/tb_cla_addsub64_pipe.sv
// ---------------------------------------------------------------------------
// tb_cla_addsub64_pipe
//
// Directed vector table with hand-computed results, hand-written sequences
// for reset, backpressure and throughput, and a long random stream checked
// in order against a 65-bit arithmetic reference.
// ---------------------------------------------------------------------------
module tb_cla_addsub64_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] res;
    logic        cout;
    logic        ovf;
    logic        zero;

    always #5 clk = ~clk;

    cla_addsub64_pipe #(.W(64)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_in_valid  (in_valid),
        .o_in_ready  (in_ready),
        .i_op        (op),
        .i_a         (a),
        .i_b         (b),
        .i_cin       (cin),
        .o_out_valid (out_valid),
        .i_out_ready (out_ready),
        .o_res       (res),
        .o_cout      (cout),
        .o_ovf       (ovf),
        .o_zero      (zero)
    );

    typedef struct {
        logic        op;
        logic [63:0] a;
        logic [63:0] b;
        logic        cin;
        logic [63:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } vec_t;

    typedef struct packed {
        logic [63:0] res;
        logic        cout;
        logic        ovf;
        logic        zero;
    } exp_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   n_acc    = 0;
    int   n_out    = 0;
    logic last_acc = 1'b0;
    exp_t q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
        end
    endtask

    // Reference: plain 65-bit arithmetic, carry into bit 63 from a 63-bit add.
    function automatic exp_t model(input logic o, input logic [63:0] x, input logic [63:0] y,
                                   input logic c);
        exp_t        m;
        logic [63:0] yy;
        logic        ci;
        logic [64:0] s;
        logic [63:0] s63;
        yy     = o ? ~y : y;
        ci     = o ^ c;
        s      = {1'b0, x} + {1'b0, yy} + {64'd0, ci};
        s63    = {1'b0, x[62:0]} + {1'b0, yy[62:0]} + {63'd0, ci};
        m.res  = s[63:0];
        m.cout = o ^ s[64];
        m.ovf  = s[64] ^ s63[63];
        m.zero = (s[63:0] == 64'd0);
        return m;
    endfunction

    // One clock: observe handshakes at the negedge, return 1 ns after posedge.
    task automatic tick();
        exp_t e;
        exp_t g;
        @(negedge clk);
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            q.push_back(model(op, a, b, cin));
            n_acc++;
        end
        if (out_valid && out_ready) begin
            n_out++;
            g = {res, cout, ovf, zero};
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: actual res=0x%016h required no output", res);
            end else begin
                e = q.pop_front();
                chk("stream_out", g, e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic rand_beat();
        op  = 1'($urandom_range(0, 1));
        cin = 1'($urandom_range(0, 1));
        a   = {$urandom, $urandom};
        b   = {$urandom, $urandom};
        case ($urandom_range(0, 7))
            0: a = '1;
            1: b = a;
            2: b = '1;
            3: a = 64'h7FFF_FFFF_FFFF_FFFF;
            default: ;
        endcase
    endtask

    vec_t vt[9];

    initial begin
        int          base;
        int          cyc;
        logic [63:0] held;

        vt[0] = '{op:0, a:64'hFFFF_FFFF_FFFF_FFFF, b:64'h0, cin:1,
                  res:64'h0, cout:1, ovf:0, zero:1};
        vt[1] = '{op:1, a:64'h0, b:64'h1, cin:0,
                  res:64'hFFFF_FFFF_FFFF_FFFF, cout:1, ovf:0, zero:0};
        vt[2] = '{op:1, a:64'h5, b:64'h3, cin:1,
                  res:64'h1, cout:0, ovf:0, zero:0};
        vt[3] = '{op:0, a:64'h7FFF_FFFF_FFFF_FFFF, b:64'h1, cin:0,
                  res:64'h8000_0000_0000_0000, cout:0, ovf:1, zero:0};
        vt[4] = '{op:0, a:64'h0000_0000_FFFF_FFFF, b:64'h1, cin:0,
                  res:64'h0000_0001_0000_0000, cout:0, ovf:0, zero:0};
        vt[5] = '{op:1, a:64'h8000_0000_0000_0000, b:64'h1, cin:0,
                  res:64'h7FFF_FFFF_FFFF_FFFF, cout:0, ovf:1, zero:0};
        vt[6] = '{op:1, a:64'h1234_5678_9ABC_DEF0, b:64'h1234_5678_9ABC_DEF0, cin:0,
                  res:64'h0, cout:0, ovf:0, zero:1};
        vt[7] = '{op:0, a:64'hFFFF_FFFF_FFFF_FFFF, b:64'hFFFF_FFFF_FFFF_FFFF, cin:1,
                  res:64'hFFFF_FFFF_FFFF_FFFF, cout:1, ovf:0, zero:0};
        vt[8] = '{op:1, a:64'h0, b:64'h0, cin:1,
                  res:64'hFFFF_FFFF_FFFF_FFFF, cout:1, ovf:0, zero:0};

        rst = 1'b1; in_valid = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_res", res, 0);
        chk("reset_flags", {cout, ovf, zero}, 0);
        chk("reset_in_ready", in_ready, 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed table: one beat at a time, latency checked exactly.
        for (int i = 0; i < 9; i++) begin
            op = vt[i].op; a = vt[i].a; b = vt[i].b; cin = vt[i].cin;
            in_valid = 1'b1;
            @(negedge clk);
            chk("vec_in_ready", in_ready, 1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            a = '1; b = '1;  // idle inputs must be ignored
            @(negedge clk);
            chk("vec_latency_early", out_valid, 0);
            @(negedge clk);
            chk("vec_latency_valid", out_valid, 1);
            chk("vec_res", res, vt[i].res);
            chk("vec_cout", cout, vt[i].cout);
            chk("vec_ovf", ovf, vt[i].ovf);
            chk("vec_zero", zero, vt[i].zero);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        chk("vec_drained", out_valid, 0);
        @(posedge clk);
        #1;

        // Backpressure: offer 5 beats with the consumer stalled.
        out_ready = 1'b0;
        base = n_acc;
        rand_beat();
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (last_acc) rand_beat();
        end
        chk("bp_accepted", n_acc - base, 2);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_in_ready_low", in_ready, 0);
        held = res;
        repeat (3) @(negedge clk);
        chk("bp_out_valid_held", out_valid, 1);
        chk("bp_res_stable", res, held);
        @(posedge clk);
        #1;
        base = n_out;
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("bp_drained_count", n_out - base, 2);
        chk("bp_queue_empty", q.size(), 0);
        chk("bp_no_duplicate", out_valid, 0);

        // Reset with both stages full.
        out_ready = 1'b0;
        in_valid = 1'b1;
        rand_beat();
        tick();
        rand_beat();
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_in_ready", in_ready, 0);
        chk("full_out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_res", res, 0);
        chk("midrst_in_ready", in_ready, 1);
        q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        out_ready = 1'b1;
        base = n_out;
        for (int i = 0; i < 3; i++) tick();
        chk("midrst_no_output", n_out - base, 0);
        rand_beat();
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("postrst_first_output", n_out - base, 1);

        // Throughput: valid and ready held high.
        base = n_acc;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rand_beat();
            tick();
        end
        chk("tput_accepts", n_acc - base, 20);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        chk("tput_queue_empty", q.size(), 0);

        // Random streaming with random valid/ready.
        base = n_acc;
        cyc = 0;
        in_valid = 1'b0;
        last_acc = 1'b0;
        while ((n_acc - base) < 10000 && cyc < 60000) begin
            if (!in_valid || last_acc) begin
                in_valid = ($urandom_range(0, 3) != 0);
                rand_beat();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
            cyc++;
        end
        chk("rand_beats_accepted", n_acc - base, 10000);
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("rand_queue_empty", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
